// File: rtl/fme_sad_select.sv
// Fractional-pel SAD accumulator and best-candidate selector over an 8x8 block.
// Candidate groups stream in row by row. Each group's SADs are reduced to a
// minimum and folded into a running best. The block result is a one-cycle pulse.
module fme_sad_select #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned BLK_W     = 8,
  parameter int unsigned BLK_H     = 8,
  parameter int unsigned NUM_CAND  = 3,
  parameter int unsigned NUM_GRP   = 9
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CAND*BLK_W*DATAWIDTH-1:0] pred_row,
  input  logic [BLK_W*DATAWIDTH-1:0]          orig_row,
  output logic                                out_valid,
  output logic [DATAWIDTH+5:0]                best_sad,
  output logic [4:0]                          best_idx
);

  localparam int unsigned SAD_W   = DATAWIDTH + $clog2(BLK_W) + $clog2(BLK_H);
  localparam int unsigned ROW_W   = DATAWIDTH + $clog2(BLK_W);
  localparam int unsigned ROW_CW  = $clog2(BLK_H);
  localparam int unsigned GRP_CW  = $clog2(NUM_GRP);
  localparam int unsigned CAND_IW = $clog2(NUM_CAND);
  localparam int unsigned IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  logic [ROW_CW-1:0]   row_cnt;
  logic [GRP_CW-1:0]   grp_cnt;
  logic [SAD_W-1:0]    acc [NUM_CAND];
  logic [SAD_W-1:0]    run_best;
  logic [IDX_W-1:0]    run_idx;

  logic [ROW_W-1:0]    row_sad [NUM_CAND];
  logic [SAD_W-1:0]    grp_min;
  logic [CAND_IW-1:0]  grp_sel;
  logic [IDX_W-1:0]    cand_idx;
  logic                take_grp;
  logic [SAD_W-1:0]    new_best;
  logic [IDX_W-1:0]    new_idx;
  logic                beat;

  function automatic logic [DATAWIDTH-1:0] abs_diff(input logic [DATAWIDTH-1:0] a,
                                                   input logic [DATAWIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign beat = in_valid & in_ready;

  // Row SAD per candidate: sum of absolute sample differences across the row
  always_comb begin
    for (int c = 0; c < NUM_CAND; c++) begin
      row_sad[c] = '0;
      for (int s = 0; s < BLK_W; s++) begin
        row_sad[c] = row_sad[c] + ROW_W'(abs_diff(pred_row[(c*BLK_W+s)*DATAWIDTH +: DATAWIDTH],
                                                   orig_row[s*DATAWIDTH +: DATAWIDTH]));
      end
    end
  end

  // Group minimum, strict less-than so the lowest candidate index wins ties
  always_comb begin
    grp_min = acc[0];
    grp_sel = '0;
    for (int c = 1; c < NUM_CAND; c++) begin
      if (acc[c] < grp_min) begin
        grp_min = acc[c];
        grp_sel = CAND_IW'(c);
      end
    end
  end

  // Fold the group minimum into the running best; earlier groups keep ties
  always_comb begin
    cand_idx = IDX_W'(grp_cnt) * IDX_W'(NUM_CAND) + IDX_W'(grp_sel);
    take_grp = (grp_min < run_best);
    new_best = take_grp ? grp_min  : run_best;
    new_idx  = take_grp ? cand_idx : run_idx;
  end

  // Control FSM with accumulators, running best and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      best_sad  <= '0;
      best_idx  <= '0;
      row_cnt   <= '0;
      grp_cnt   <= '0;
      run_best  <= '1;
      run_idx   <= '0;
      for (int c = 0; c < NUM_CAND; c++) acc[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            for (int c = 0; c < NUM_CAND; c++) acc[c] <= SAD_W'(row_sad[c]);
            row_cnt <= ROW_CW'(1);
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            for (int c = 0; c < NUM_CAND; c++) acc[c] <= acc[c] + SAD_W'(row_sad[c]);
            if (row_cnt == ROW_CW'(BLK_H - 1)) begin
              row_cnt  <= '0;
              in_ready <= 1'b0;
              state    <= COMPARE;
            end else begin
              row_cnt <= row_cnt + ROW_CW'(1);
            end
          end
        end
        COMPARE: begin
          run_best <= new_best;
          run_idx  <= new_idx;
          if (grp_cnt == GRP_CW'(NUM_GRP - 1)) begin
            out_valid <= 1'b1;
            best_sad  <= new_best;
            best_idx  <= new_idx;
            state     <= DONE;
          end else begin
            grp_cnt  <= grp_cnt + GRP_CW'(1);
            for (int c = 0; c < NUM_CAND; c++) acc[c] <= '0;
            in_ready <= 1'b1;
            state    <= ACCUM;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          run_best  <= '1;
          run_idx   <= '0;
          grp_cnt   <= '0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
